wash_sequencer: RTL and testbench

- Program sequencer for the washer datapath. It steps through fill, wash, drain, rinse (repeated), drain and spin phases.
- Drives the valve and phase lights, tracks the remaining and total time, handles pause/resume and the lid interlock, and raises the finish, buzzer and auto-power-off request.
- Sits between the debounced panel keys and the display/light drivers. Timing comes from a 1 Hz enable pulse that is synchronous to clk.

---
 rtl/washer_pkg.sv | 41 ++++
 rtl/phase_timer.sv | 25 ++
 rtl/wash_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// rtl/washer_pkg.sv - state encoding, mode bits, timing defaults and level clamp for the washer sequencer
package washer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FILL_W  = 4'd1,
        ST_WASH    = 4'd2,
        ST_DRAIN_W = 4'd3,
        ST_FILL_R  = 4'd4,
        ST_RINSE   = 4'd5,
        ST_DRAIN_R = 4'd6,
        ST_SPIN    = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    localparam int MODE_WASH  = 0;
    localparam int MODE_RINSE = 1;
    localparam int MODE_SPIN  = 2;

    localparam int DEF_WASH_SEC   = 9;
    localparam int DEF_RINSE_SEC  = 6;
    localparam int DEF_DRAIN_SEC  = 2;
    localparam int DEF_SPIN_SEC   = 3;
    localparam int DEF_RINSE_REPS = 2;
    localparam int DEF_BUZZ_SEC   = 3;
    localparam int DEF_OFF_SEC    = 10;

    localparam logic [2:0] LVL_MIN = 3'd1;
    localparam logic [2:0] LVL_MAX = 3'd5;

    // Map the raw level selector onto the supported 1..5 range
    function automatic logic [2:0] clamp_level(input logic [2:0] raw);
        if (raw < LVL_MIN)
            return LVL_MIN;
        else if (raw > LVL_MAX)
            return LVL_MAX;
        else
            return raw;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable 7-bit down-counter with enable and expiry flag
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       en,
    output logic [6:0] count,
    output logic       expire
);

    // Load has priority over counting; the count parks at zero once expired
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= 7'd0;
        else if (load)
            count <= load_val;
        else if (en && count != 7'd0)
            count <= count - 7'd1;
    end

    // The enabled tick that takes the count from 1 to 0
    assign expire = en && (count == 7'd1);

endmodule

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - washer program sequencer: phases, valves, lights, pause, lid interlock and finish handling
module wash_sequencer
    import washer_pkg::*;
#(
    parameter int WASH_SEC   = DEF_WASH_SEC,
    parameter int RINSE_SEC  = DEF_RINSE_SEC,
    parameter int DRAIN_SEC  = DEF_DRAIN_SEC,
    parameter int SPIN_SEC   = DEF_SPIN_SEC,
    parameter int RINSE_REPS = DEF_RINSE_REPS,
    parameter int BUZZ_SEC   = DEF_BUZZ_SEC,
    parameter int OFF_SEC    = DEF_OFF_SEC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       power_on,
    input  logic       start_pause,
    input  logic [2:0] mode,
    input  logic [2:0] water_level,
    input  logic       lid_closed,
    output logic [3:0] state,
    output logic       inwater,
    output logic       outwater,
    output logic       wash_on,
    output logic       rinse_on,
    output logic       spin_on,
    output logic       paused,
    output logic [6:0] remain_sec,
    output logic [6:0] total_sec,
    output logic       finish,
    output logic       buzzer,
    output logic       power_off_req
);

    state_t     state_q;
    state_t     nxt_state;
    logic [2:0] mode_q;
    logic [2:0] lvl_q;
    logic [2:0] lvl_in;
    logic [1:0] rinse_cnt;
    logic [1:0] nxt_rinse_cnt;
    logic       nxt_paused;
    logic       nxt_buzzer;
    logic       nxt_req;
    logic [6:0] nxt_remain;
    logic [6:0] nxt_total;
    logic [6:0] preview;
    logic       active;
    logic       tmr_load;
    logic [6:0] tmr_val;
    logic       tmr_en;
    logic [6:0] tmr_count;
    logic       tmr_expire;

    function automatic logic [6:0] calc_total(input logic [2:0] m, input logic [2:0] lvl);
        int t;
        t = 0;
        if (m[MODE_WASH])
            t = t + int'(lvl) + WASH_SEC + DRAIN_SEC;
        if (m[MODE_RINSE])
            t = t + RINSE_REPS * (int'(lvl) + RINSE_SEC + DRAIN_SEC);
        if (m[MODE_SPIN])
            t = t + SPIN_SEC;
        if (t > 127)
            t = 127;
        return t[6:0];
    endfunction

    // First enabled phase group; masking off finished groups reuses it for later hand-offs
    function automatic state_t first_phase(input logic [2:0] m);
        if (m[MODE_WASH])
            return ST_FILL_W;
        else if (m[MODE_RINSE])
            return ST_FILL_R;
        else if (m[MODE_SPIN])
            return ST_SPIN;
        else
            return ST_DONE;
    endfunction

    function automatic logic [6:0] phase_len(input state_t s, input logic [2:0] lvl);
        case (s)
            ST_FILL_W, ST_FILL_R:   return {4'd0, lvl};
            ST_WASH:                return 7'(WASH_SEC);
            ST_RINSE:               return 7'(RINSE_SEC);
            ST_DRAIN_W, ST_DRAIN_R: return 7'(DRAIN_SEC);
            ST_SPIN:                return 7'(SPIN_SEC);
            ST_DONE:                return 7'(OFF_SEC);
            default:                return 7'd0;
        endcase
    endfunction

    assign lvl_in  = clamp_level(water_level);
    assign preview = calc_total(mode, lvl_in);
    assign active  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    // A key press in the same cycle as a tick swallows that tick
    assign tmr_en  = power_on && tick_1hz && !start_pause &&
                     ((active && !paused && lid_closed) || (state_q == ST_DONE));
    assign state   = state_q;

    phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    // Next phase, pause flag, time displays and timer reload
    always_comb begin
        nxt_state     = state_q;
        nxt_paused    = paused;
        nxt_rinse_cnt = rinse_cnt;
        nxt_remain    = remain_sec;
        nxt_total     = total_sec;
        nxt_buzzer    = buzzer;
        nxt_req       = 1'b0;
        tmr_load      = 1'b0;
        tmr_val       = 7'd0;
        if (!power_on) begin
            nxt_state     = ST_IDLE;
            nxt_paused    = 1'b0;
            nxt_rinse_cnt = 2'd0;
            nxt_remain    = 7'd0;
            nxt_total     = 7'd0;
            nxt_buzzer    = 1'b0;
            tmr_load      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    nxt_remain = preview;
                    nxt_total  = preview;
                    if (start_pause && lid_closed && mode != 3'b000) begin
                        nxt_state     = first_phase(mode);
                        nxt_rinse_cnt = 2'd0;
                        tmr_load      = 1'b1;
                        tmr_val       = phase_len(first_phase(mode), lvl_in);
                    end
                end
                ST_DONE: begin
                    nxt_remain = 7'd0;
                    if (start_pause || power_off_req) begin
                        nxt_state  = ST_IDLE;
                        nxt_buzzer = 1'b0;
                        nxt_remain = preview;
                        nxt_total  = preview;
                        tmr_load   = 1'b1;
                    end else if (tmr_en) begin
                        nxt_buzzer = (int'(tmr_count) - 1) > (OFF_SEC - BUZZ_SEC);
                        nxt_req    = tmr_expire;
                    end
                end
                default: begin
                    if (!lid_closed)
                        nxt_paused = 1'b1;
                    else if (start_pause)
                        nxt_paused = !paused;
                    if (tmr_en && remain_sec != 7'd0)
                        nxt_remain = remain_sec - 7'd1;
                    if (tmr_expire) begin
                        case (state_q)
                            ST_FILL_W:  nxt_state = ST_WASH;
                            ST_WASH:    nxt_state = ST_DRAIN_W;
                            ST_DRAIN_W: nxt_state = first_phase(mode_q & 3'b110);
                            ST_FILL_R:  nxt_state = ST_RINSE;
                            ST_RINSE:   nxt_state = ST_DRAIN_R;
                            ST_DRAIN_R: begin
                                nxt_rinse_cnt = rinse_cnt + 2'd1;
                                nxt_state = (int'(rinse_cnt) + 1 < RINSE_REPS) ?
                                            ST_FILL_R : first_phase(mode_q & 3'b100);
                            end
                            default:    nxt_state = ST_DONE;
                        endcase
                        tmr_load = 1'b1;
                        tmr_val  = phase_len(nxt_state, lvl_q);
                        if (nxt_state == ST_DONE) begin
                            nxt_remain = 7'd0;
                            nxt_buzzer = (BUZZ_SEC > 0);
                        end
                    end
                end
            endcase
        end
    end

    // Phase register plus all registered lamp, valve and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            mode_q        <= 3'd0;
            lvl_q         <= 3'd0;
            rinse_cnt     <= 2'd0;
            paused        <= 1'b0;
            inwater       <= 1'b0;
            outwater      <= 1'b0;
            wash_on       <= 1'b0;
            rinse_on      <= 1'b0;
            spin_on       <= 1'b0;
            finish        <= 1'b0;
            buzzer        <= 1'b0;
            power_off_req <= 1'b0;
            remain_sec    <= 7'd0;
            total_sec     <= 7'd0;
        end else begin
            state_q   <= nxt_state;
            rinse_cnt <= nxt_rinse_cnt;
            paused    <= nxt_paused;
            if (state_q == ST_IDLE && nxt_state != ST_IDLE) begin
                mode_q <= mode;
                lvl_q  <= lvl_in;
            end
            inwater       <= (nxt_state inside {ST_FILL_W, ST_FILL_R}) && !nxt_paused;
            outwater      <= (nxt_state inside {ST_DRAIN_W, ST_DRAIN_R, ST_SPIN}) && !nxt_paused;
            wash_on       <= nxt_state inside {ST_FILL_W, ST_WASH, ST_DRAIN_W};
            rinse_on      <= nxt_state inside {ST_FILL_R, ST_RINSE, ST_DRAIN_R};
            spin_on       <= (nxt_state == ST_SPIN);
            finish        <= (nxt_state == ST_DONE);
            buzzer        <= nxt_buzzer;
            power_off_req <= nxt_req;
            remain_sec    <= nxt_remain;
            total_sec     <= nxt_total;
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - scoreboard bench for the washer program sequencer
module tb_wash_sequencer;
    import washer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       power_on;
    logic       start_pause;
    logic [2:0] mode;
    logic [2:0] water_level;
    logic       lid_closed;
    logic [3:0] state;
    logic       inwater, outwater, wash_on, rinse_on, spin_on, paused;
    logic [6:0] remain_sec, total_sec;
    logic       finish, buzzer, power_off_req;

    always #5 clk = ~clk;

    wash_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .tick_1hz      (tick_1hz),
        .power_on      (power_on),
        .start_pause   (start_pause),
        .mode          (mode),
        .water_level   (water_level),
        .lid_closed    (lid_closed),
        .state         (state),
        .inwater       (inwater),
        .outwater      (outwater),
        .wash_on       (wash_on),
        .rinse_on      (rinse_on),
        .spin_on       (spin_on),
        .paused        (paused),
        .remain_sec    (remain_sec),
        .total_sec     (total_sec),
        .finish        (finish),
        .buzzer        (buzzer),
        .power_off_req (power_off_req)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic seen_rs;

    // Expected {inwater,outwater,wash_on,rinse_on,spin_on} for an unpaused phase
    function automatic logic [4:0] lamps(input logic [3:0] st);
        case (st)
            4'd1:    return 5'b10100;
            4'd2:    return 5'b00100;
            4'd3:    return 5'b01100;
            4'd4:    return 5'b10010;
            4'd5:    return 5'b00010;
            4'd6:    return 5'b01010;
            4'd7:    return 5'b01001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [26:0] all_out();
        return {state, inwater, outwater, wash_on, rinse_on, spin_on, paused,
                finish, buzzer, power_off_req, remain_sec, total_sec};
    endfunction

    task automatic expect_v(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] exp, input logic [31:0] obs);
        expect_v(tag, exp);
        compare(obs);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        if (rinse_on || spin_on)
            seen_rs = 1'b1;
    endtask

    task automatic key();
        start_pause = 1'b1;
        step();
        start_pause = 1'b0;
    endtask

    task automatic push_phase(input logic [3:0] st, input int n);
        expect_v($sformatf("phase_state_%0d", st), st);
        expect_v($sformatf("phase_lamps_%0d", st), lamps(st));
        expect_v($sformatf("phase_ticks_%0d", st), n);
    endtask

    task automatic run_phases(input int nph);
        for (int i = 0; i < nph; i++) begin
            logic [3:0] cur;
            int         cnt;
            cur = state;
            compare(state);
            compare({inwater, outwater, wash_on, rinse_on, spin_on});
            cnt = 0;
            while (state === cur && cnt < 100) begin
                tick();
                cnt++;
            end
            compare(cnt);
        end
    endtask

    task automatic wait_state(input logic [3:0] st, input string tag);
        int cnt;
        cnt = 0;
        while (state !== st && cnt < 100) begin
            tick();
            cnt++;
        end
        chk(tag, st, state);
    endtask

    initial begin
        reset       = 1'b0;
        tick_1hz    = 1'b0;
        power_on    = 1'b0;
        start_pause = 1'b0;
        lid_closed  = 1'b1;
        mode        = 3'b000;
        water_level = 3'd0;
        seen_rs     = 1'b0;
        #12;
        chk("reset_outputs", 0, all_out());

        // Full program, level 3
        reset       = 1'b1;
        power_on    = 1'b1;
        mode        = 3'b111;
        water_level = 3'd3;
        step();
        step();
        chk("preview_total_111", 39, total_sec);
        chk("preview_remain_111", 39, remain_sec);
        push_phase(ST_FILL_W, 3);
        push_phase(ST_WASH, 9);
        push_phase(ST_DRAIN_W, 2);
        for (int r = 0; r < 2; r++) begin
            push_phase(ST_FILL_R, 3);
            push_phase(ST_RINSE, 6);
            push_phase(ST_DRAIN_R, 2);
        end
        push_phase(ST_SPIN, 3);
        key();
        run_phases(10);
        chk("done_state", ST_DONE, state);
        chk("done_remain", 0, remain_sec);
        chk("done_finish", 1, finish);
        chk("done_total_held", 39, total_sec);
        chk("buzz_t0", 1, buzzer);
        tick();
        chk("buzz_t1", 1, buzzer);
        tick();
        chk("buzz_t2", 1, buzzer);
        tick();
        chk("buzz_t3", 0, buzzer);
        repeat (6) tick();
        chk("no_req_t9", 0, power_off_req);
        chk("still_done_t9", ST_DONE, state);
        tick();
        chk("req_t10", 1, power_off_req);
        step();
        chk("idle_after_req", ST_IDLE, state);
        chk("req_pulse_end", 0, power_off_req);

        // Wash only, level 2
        mode        = 3'b001;
        water_level = 3'd2;
        step();
        chk("preview_total_001", 13, total_sec);
        push_phase(ST_FILL_W, 2);
        push_phase(ST_WASH, 9);
        push_phase(ST_DRAIN_W, 2);
        seen_rs = 1'b0;
        key();
        run_phases(3);
        chk("wash_only_done", ST_DONE, state);
        chk("no_rinse_spin_lamps", 0, seen_rs);
        key();
        chk("key_in_done_idle", ST_IDLE, state);
        chk("no_req_on_key", 0, power_off_req);

        // Spin only, then an empty mode
        mode = 3'b100;
        step();
        chk("preview_total_100", 3, total_sec);
        push_phase(ST_SPIN, 3);
        key();
        run_phases(1);
        chk("spin_only_done", ST_DONE, state);
        key();
        mode = 3'b000;
        step();
        key();
        chk("mode0_stays_idle", ST_IDLE, state);

        // Pause and resume in WASH
        mode        = 3'b111;
        water_level = 3'd3;
        step();
        key();
        repeat (9) tick();
        chk("wash_state", ST_WASH, state);
        chk("remain_30", 30, remain_sec);
        key();
        chk("paused_set", 1, paused);
        chk("paused_lamps", 5'b00100, {inwater, outwater, wash_on, rinse_on, spin_on});
        repeat (5) tick();
        chk("frozen_30", 30, remain_sec);
        start_pause = 1'b1;
        tick_1hz    = 1'b1;
        step();
        start_pause = 1'b0;
        tick_1hz    = 1'b0;
        chk("resumed", 0, paused);
        chk("resume_tick_dropped", 30, remain_sec);
        tick();
        chk("decrement_29", 29, remain_sec);
        start_pause = 1'b1;
        tick_1hz    = 1'b1;
        step();
        start_pause = 1'b0;
        tick_1hz    = 1'b0;
        chk("pause_with_tick", 1, paused);
        chk("pause_tick_dropped", 29, remain_sec);
        key();
        tick();
        chk("decrement_28", 28, remain_sec);

        // Lid interlock in FILL_R
        wait_state(ST_FILL_R, "reach_fill_r");
        chk("fill_r_remain", 25, remain_sec);
        lid_closed = 1'b0;
        step();
        chk("lid_open_paused", 1, paused);
        chk("lid_open_valve_off", 0, inwater);
        key();
        chk("key_ignored_lid_open", 1, paused);
        tick();
        chk("lid_open_frozen", 25, remain_sec);
        lid_closed = 1'b1;
        step();
        chk("lid_closed_still_paused", 1, paused);
        key();
        chk("lid_resume", 0, paused);
        chk("inwater_back", 1, inwater);

        // Power loss in RINSE
        wait_state(ST_RINSE, "reach_rinse");
        power_on = 1'b0;
        step();
        chk("power_off_all_zero", 0, all_out());
        key();
        chk("keys_ignored_power_off", ST_IDLE, state);
        power_on = 1'b1;
        step();

        // Asynchronous reset in SPIN
        mode = 3'b100;
        step();
        key();
        chk("spin_entry", ST_SPIN, state);
        tick();
        reset = 1'b0;
        #1;
        chk("async_reset_idle", 0, all_out());
        @(negedge clk);
        reset = 1'b1;
        step();

        // Out-of-range level clamps to 5
        mode        = 3'b001;
        water_level = 3'd7;
        step();
        chk("level7_preview", 16, total_sec);
        push_phase(ST_FILL_W, 5);
        key();
        run_phases(1);
        chk("level7_wash", ST_WASH, state);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
